// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// Pipeline stage register with a valid/ready handshake and a two-entry skid
// buffer. It sits between two pipeline stages (ID->EXE, EXE->MEM, MEM->WB).
// The main register drives the outputs. The skid register catches the one
// entry that can arrive in the cycle after downstream stops accepting.
//
// Each entry carries a control field (write enables, branch bits, EXE
// command, ...) and a data payload (PC, operand values, register indices).
// The control field is forced to zero in any slot that holds a bubble, so a
// downstream stage can never act on stale control bits.
//
// Parameters
//   CTRL_W    width of the control field (cleared on reset/flush/bubble)
//   DATA_W    width of the data payload
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous flush, drops held entries and same-cycle input
//   in_valid   in   upstream presents an entry
//   in_ready   out  stage can accept an entry (decode of state only)
//   in_ctrl    in   control field of the incoming entry
//   in_data    in   data payload of the incoming entry
//   out_valid  out  stage presents an entry downstream
//   out_ready  in   downstream accepts the presented entry
//   out_ctrl   out  control field of the held entry, 0 for a bubble
//   out_data   out  data payload of the held entry
//   occupancy  out  number of held entries, 0..2
//
// Optional feature
//   PIPE_STAGE_REG_ZERO_DATA_EN  when defined, reset, flush and every slot
//   that becomes empty also clear the data register, so out_data reads 0
//   whenever out_valid is 0. When undefined, the data registers have no
//   reset and no clear and simply hold their last captured value.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding equals the number of held entries, so the occupancy output
  // is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_mainCtrl;
  logic [DATA_W-1:0]   r_mainData;
  logic [CTRL_W-1:0]   r_skidCtrl;
  logic [DATA_W-1:0]   r_skidData;

  state_t              w_nextState;
  logic                w_inFire;
  logic                w_outFire;
  logic                w_loadMainIn;
  logic                w_loadMainSkid;
  logic                w_loadSkidIn;
  logic                w_clearMain;
  logic                w_clearSkid;

  // in_ready depends on the state register alone, which keeps out_ready off
  // the upstream ready path; the skid slot absorbs the one-cycle lag.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_state;
  assign out_ctrl  = r_mainCtrl;
  assign out_data  = r_mainData;

  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = out_valid & out_ready;

  // Next-state decode. Besides the next state it produces one strobe per
  // register move, so the control and data registers share one decision.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkidIn   = 1'b0;
    w_clearMain    = 1'b0;
    w_clearSkid    = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_inFire) begin
          w_nextState  = ONE;
          w_loadMainIn = 1'b1;
        end
      end
      ONE: begin
        if (w_inFire && w_outFire) begin
          w_loadMainIn = 1'b1;
        end else if (w_inFire) begin
          w_nextState  = FULL;
          w_loadSkidIn = 1'b1;
        end else if (w_outFire) begin
          w_nextState = EMPTY;
          w_clearMain = 1'b1;
        end
      end
      FULL: begin
        // The skid entry was queued behind main, so it moves forward only
        // when main leaves; this keeps the order strictly FIFO.
        if (w_outFire) begin
          w_nextState    = ONE;
          w_loadMainSkid = 1'b1;
          w_clearSkid    = 1'b1;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  // State and control registers. Reset wins over flush, and both discard any
  // same-cycle transfer. Control bits are zeroed whenever a slot empties.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= EMPTY;
      r_mainCtrl <= '0;
      r_skidCtrl <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadMainIn) begin
        r_mainCtrl <= in_ctrl;
      end else if (w_loadMainSkid) begin
        r_mainCtrl <= r_skidCtrl;
      end else if (w_clearMain) begin
        r_mainCtrl <= '0;
      end
      if (w_loadSkidIn) begin
        r_skidCtrl <= in_ctrl;
      end else if (w_clearSkid) begin
        r_skidCtrl <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_REG_ZERO_DATA_EN
  // Data registers with clearing: an empty slot always reads zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_mainData <= '0;
      r_skidData <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_mainData <= in_data;
      end else if (w_loadMainSkid) begin
        r_mainData <= r_skidData;
      end else if (w_clearMain) begin
        r_mainData <= '0;
      end
      if (w_loadSkidIn) begin
        r_skidData <= in_data;
      end else if (w_clearSkid) begin
        r_skidData <= '0;
      end
    end
  end
`else
  // Data registers without reset or clear: they only load on a capture and
  // otherwise keep their last value. A capture in a reset/flush cycle is
  // dropped along with the entry.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_loadMainIn) begin
        r_mainData <= in_data;
      end else if (w_loadMainSkid) begin
        r_mainData <= r_skidData;
      end
      if (w_loadSkidIn) begin
        r_skidData <= in_data;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer, used between any two pipeline stages, e.g. ID to EXE, EXE to MEM, and MEM to WB. It carries a control field and a data payload:

- **Control field:** WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, SR, etc. It is always zero whenever the stage holds a bubble.
- **Data payload:** PC, Val_Rn, Val_Rm, operands, Dest/Src indices.

The block supports back-pressure, which lets hazard-unit stalls propagate without losing an instruction. It also supports a synchronous flush, used on a taken branch.

## Interface
Parameters:
- CTRL_W, 8: width of the control field; cleared on reset, flush and bubble.
- DATA_W, 128: width of the data payload.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries and any same-cycle input.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  control field of the incoming entry.
- in_data  in  DATA_W  data payload of the incoming entry.
- out_valid  out  1  stage presents an entry downstream.
- out_ready  in  1  downstream accepts the presented entry.
- out_ctrl  out  CTRL_W  control field of the held entry; 0 when out_valid=0.
- out_data  out  DATA_W  data payload of the held entry.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Storage: main register (drives out_*) plus one skid register.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- in_ready = (state != FULL). It is a decode of the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire & !out_fire -> FULL, skid<=in.
  - ONE, !in_fire & out_fire -> EMPTY, main ctrl<=0.
  - ONE, otherwise: hold.
  - FULL, out_fire -> ONE, main<=skid, skid ctrl<=0.
  - FULL, otherwise: hold; in_valid is ignored since in_ready=0.
- Priority: rst > flush > normal transitions.
- rst or flush:
  - state<=EMPTY.
  - main and skid ctrl<=0.
  - A same-cycle in_fire or out_fire is discarded. Upstream must not treat that input as consumed, and downstream must not treat that output as delivered.
- Ordering: strictly FIFO. An entry placed in skid always leaves after the main entry it was queued behind.
- out_ctrl is a registered value that is already zero for bubbles. No AND gating is applied on the output path.
- Data registers:
  - Load only on capture (main<=in, skid<=in, main<=skid).
  - Otherwise they hold, unless the ZERO_DATA feature below is enabled.

## Timing
- Latency: in_fire at edge N -> out_valid=1 with that entry's fields after edge N (1 cycle).
- Throughput: 1 entry/cycle with out_ready held high; occupancy stays at 1.
- Back-pressure: when out_ready drops, in_ready drops one cycle later at the earliest. The entry accepted in the meantime lands in skid, so nothing is lost.
- Stall release: FULL with out_ready=1 drains one entry per cycle. in_ready returns high the cycle after the first out_fire.
- Values during and after reset:
  - in_ready=1.
  - out_valid=0.
  - out_ctrl=0.
  - occupancy=0.
  - out_data per Configuration.
- Flush: one cycle produces EMPTY on the next edge. in_ready=1 in the following cycle.

## Configuration
- Macro: PIPE_STAGE_REG_ZERO_DATA_EN.
- Defined:
  - rst, flush and every transition into a non-holding slot (main->EMPTY, skid drained) also clear the corresponding data register to 0.
  - out_data==0 whenever out_valid==0.
- Not defined:
  - Data registers have no reset and no clear. They hold their last captured value, and out_data is unspecified while out_valid=0.
  - This lowers area and fan-out.

## Test plan
- Reset then stream: rst 2 cycles, then in_valid=1 with ctrl=8'hA5, data=1..4, out_ready=1.
  - Required: out_valid rises 1 cycle after the first fire.
  - Required: data 1,2,3,4 appear on consecutive cycles, occupancy=1, in_ready stays 1.
- Back-pressure: stream data 10,11,12 while out_ready=0 from the second cycle.
  - Required: occupancy reaches 2, in_ready=0, out_data=10 held.
  - Required: after out_ready=1, outputs 10,11,12 in order with no duplicate or loss.
- Flush while FULL: occupancy=2, assert flush with in_valid=1 (data 99).
  - Required: next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
  - Required: 99 never appears at the output.
- Flush/rst priority: assert rst and flush together in state ONE with in_fire.
  - Required: same result as rst; all outputs at reset values.
- Bubble ctrl: drain to EMPTY with last ctrl=8'hFF.
  - Required: out_ctrl=0 the cycle after out_valid falls.
  - With PIPE_STAGE_REG_ZERO_DATA_EN defined: out_data=0 as well.
- Random valid/ready (10k cycles, CTRL_W=1, DATA_W=32) against a scoreboard.
  - Required: FIFO order preserved, occupancy ≤2, in_ready==(occupancy!=2) every cycle.
